// File: rtl/anim_sequencer.sv
// Sprite-animation sequencer: frame-rate tick, loop/one-shot/ping-pong frame counter and a
// registered sprite-ROM address generator. Define ANIM_PINGPONG_EN to enable ping-pong mode.
module anim_sequencer #(
  parameter int N_FRAMES = 16,
  parameter int TICK_DIV = 33554432,
  parameter int SPRITE_W = 128,
  parameter int SPRITE_H = 128,
  parameter int ADDR_W   = 18
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        pause,
  input  logic [1:0]                  mode,
  input  logic [1:0]                  speed,
  input  logic [7:0]                  ram_addr_x,
  input  logic [7:0]                  ram_addr_y,
  output logic [$clog2(N_FRAMES)-1:0] frame,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        addr_valid,
  output logic                        busy,
  output logic                        done
);

  localparam int FW = $clog2(N_FRAMES);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [FW-1:0] LAST = FW'(N_FRAMES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          tick_q;
  logic [1:0]    mode_q;
  logic [31:0]   period;
  logic          tick;
  logic [FW-1:0] nxt_frame;
  logic          nxt_done;
  logic          nxt_exit;
`ifdef ANIM_PINGPONG_EN
  logic          dir;      // 0 = counting up, 1 = counting down
  logic          nxt_dir;
`endif

  // A shift of TICK_DIV to zero would never tick; clamp to one frame per cycle instead.
  always_comb begin
    period = 32'(TICK_DIV) >> speed;
    if (period == 32'd0) period = 32'd1;
  end

  assign tick = !pause && (32'(cnt) >= period - 32'd1);

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    nxt_frame = frame + 1'b1;
    nxt_done  = 1'b0;
    nxt_exit  = 1'b0;
`ifdef ANIM_PINGPONG_EN
    nxt_dir   = dir;
`endif
    case (mode_q)
      2'b01: begin
        if (frame == LAST) begin
          nxt_frame = frame;
          nxt_done  = 1'b1;
          nxt_exit  = 1'b1;
        end
      end
`ifdef ANIM_PINGPONG_EN
      2'b10: begin
        if (!dir) begin
          if (frame == LAST) begin
            nxt_frame = frame - 1'b1;
            nxt_dir   = 1'b1;
          end
        end else if (frame == '0) begin
          nxt_frame = FW'(1);
          nxt_dir   = 1'b0;
        end else begin
          nxt_frame = frame - 1'b1;
        end
        nxt_done = (nxt_frame == '0);
      end
`endif
      default: begin
        if (frame == LAST) begin
          nxt_frame = '0;
          nxt_done  = 1'b1;
        end
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples the
  // pre-edge values; done defaults low here and a later assignment in the block overrides it.
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      frame  <= '0;
      cnt    <= '0;
      tick_q <= 1'b0;
      mode_q <= 2'b00;
`ifdef ANIM_PINGPONG_EN
      dir    <= 1'b0;
`endif
    end else if (stop) begin
      state  <= IDLE;
      busy   <= 1'b0;
      frame  <= '0;
      cnt    <= '0;
      tick_q <= 1'b0;
    end else if (start) begin
      state  <= RUN;
      busy   <= 1'b1;
      frame  <= '0;
      cnt    <= '0;
      tick_q <= 1'b0;
      mode_q <= mode;
`ifdef ANIM_PINGPONG_EN
      dir    <= 1'b0;
`endif
    end else if (state == RUN) begin
      if (tick)        cnt <= '0;
      else if (!pause) cnt <= cnt + 1'b1;
      tick_q <= tick;
      // A tick registered last cycle advances the frame even if pause has since risen.
      if (tick_q) begin
        frame <= nxt_frame;
        done  <= nxt_done;
`ifdef ANIM_PINGPONG_EN
        dir   <= nxt_dir;
`endif
        if (nxt_exit) begin
          state  <= IDLE;
          busy   <= 1'b0;
          cnt    <= '0;
          tick_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr   <= '0;
      addr_valid <= 1'b0;
    end else if ((32'(ram_addr_x) < 32'(SPRITE_W)) && (32'(ram_addr_y) < 32'(SPRITE_H))) begin
      mem_addr   <= ADDR_W'(32'(frame) * 32'(SPRITE_W * SPRITE_H)
                          + 32'(ram_addr_y) * 32'(SPRITE_W) + 32'(ram_addr_x));
      addr_valid <= 1'b1;
    end else begin
      mem_addr   <= '0;
      addr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_anim_sequencer.sv
// Bench for anim_sequencer: directed literal checks plus randomized stimulus compared every
// cycle against a step-counting reference model. Honours ANIM_PINGPONG_EN like the design.
module tb_anim_sequencer;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int SW = 8;
  localparam int SH = 8;
  localparam int AW = 8;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause;
  logic [1:0] mode, speed;
  logic [7:0] ram_addr_x, ram_addr_y;
  logic [1:0] frame;
  logic [AW-1:0] mem_addr;
  logic       addr_valid, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  anim_sequencer #(
    .N_FRAMES(N), .TICK_DIV(TD), .SPRITE_W(SW), .SPRITE_H(SH), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .speed(speed), .ram_addr_x(ram_addr_x), .ram_addr_y(ram_addr_y),
    .frame(frame), .mem_addr(mem_addr), .addr_valid(addr_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: the frame is derived from the number of advances since start.
  int m_run, m_mode, m_step, m_frame, m_cnt, m_pend, m_done, e_addr, e_valid;

  always @(posedge clk) begin : model
    int per;
    int p;
    int was;
    int eff;
    if (int'(ram_addr_x) < SW && int'(ram_addr_y) < SH) begin
      e_valid = 1;
      e_addr  = (m_frame * SW * SH + int'(ram_addr_y) * SW + int'(ram_addr_x)) % (1 << AW);
    end else begin
      e_valid = 0;
      e_addr  = 0;
    end
    m_done = 0;
    if (rst) begin
      m_run = 0; m_mode = 0; m_step = 0; m_frame = 0; m_cnt = 0; m_pend = 0;
      e_valid = 0; e_addr = 0;
    end else if (stop) begin
      m_run = 0; m_frame = 0; m_cnt = 0; m_pend = 0;
    end else if (start) begin
      m_run = 1; m_mode = int'(mode); m_step = 0; m_frame = 0; m_cnt = 0; m_pend = 0;
    end else if (m_run != 0) begin
      was    = m_pend;
      m_pend = 0;
      per    = TD >> speed;
      if (per < 1) per = 1;
      if (!pause) begin
        m_cnt++;
        if (m_cnt >= per) begin
          m_pend = 1;
          m_cnt  = 0;
        end
      end
      if (was != 0) begin
        eff = (m_mode == 1) ? 1 : 0;
`ifdef ANIM_PINGPONG_EN
        if (m_mode == 2) eff = 2;
`endif
        if (eff == 1) begin
          if (m_step == N - 1) begin
            m_done = 1; m_run = 0; m_pend = 0; m_cnt = 0;
          end else begin
            m_step++;
            m_frame = m_step;
          end
        end else if (eff == 2) begin
          m_step++;
          p       = m_step % (2 * N - 2);
          m_frame = (p < N) ? p : (2 * N - 2 - p);
          m_done  = (m_frame == 0) ? 1 : 0;
        end else begin
          m_step++;
          m_frame = m_step % N;
          m_done  = (m_frame == 0) ? 1 : 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_frame", 32'(frame), m_frame);
      check("cmp_busy", 32'(busy), m_run);
      check("cmp_done", 32'(done), m_done);
      check("cmp_mem_addr", 32'(mem_addr), e_addr);
      check("cmp_addr_valid", 32'(addr_valid), e_valid);
    end
  end

  task automatic go_idle();
    start = 1'b0; pause = 1'b0; speed = 2'd0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  task automatic start_run(input logic [1:0] m, input logic [1:0] s);
    mode = m; speed = s; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    mode = 2'd0; speed = 2'd0; ram_addr_x = 8'd1; ram_addr_y = 8'd1;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    check("rst_frame", 32'(frame), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addr_valid", 32'(addr_valid), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);

    // Loop mode: frame changes every 4 clocks, done only on the 3->0 wrap.
    start_run(2'b00, 2'd0);
    check("loop_busy", 32'(busy), 1);
    repeat (4) step();
    check("loop_f0_hold", 32'(frame), 0);
    step();
    check("loop_f1", 32'(frame), 1);
    check("model_loop_f1", m_frame, 1);
    repeat (11) step();
    check("loop_f3", 32'(frame), 3);
    check("loop_no_done", 32'(done), 0);
    step();
    check("loop_wrap_frame", 32'(frame), 0);
    check("loop_wrap_done", 32'(done), 1);
    step();
    check("loop_done_pulse", 32'(done), 0);
    go_idle();
    check("stop_frame", 32'(frame), 0);
    check("stop_busy", 32'(busy), 0);

    // One-shot: runs 0..3, exits with done and holds frame 3.
    start_run(2'b01, 2'd0);
    repeat (16) step();
    check("os_f3_busy", 32'(busy), 1);
    step();
    check("os_done", 32'(done), 1);
    check("os_busy", 32'(busy), 0);
    check("os_frame", 32'(frame), 3);
    check("model_os_frame", m_frame, 3);
    repeat (10) step();
    check("os_hold_frame", 32'(frame), 3);
    check("os_hold_done", 32'(done), 0);
    go_idle();

    // Mode 10: ping-pong when enabled, plain loop otherwise.
    start_run(2'b10, 2'd0);
`ifdef ANIM_PINGPONG_EN
    repeat (17) step();
    check("pp_down_f2", 32'(frame), 2);
    repeat (4) step();
    check("pp_f1", 32'(frame), 1);
    repeat (4) step();
    check("pp_f0", 32'(frame), 0);
    check("pp_done", 32'(done), 1);
    repeat (4) step();
    check("pp_up_f1", 32'(frame), 1);
`else
    repeat (17) step();
    check("m10_wrap_frame", 32'(frame), 0);
    check("m10_wrap_done", 32'(done), 1);
`endif
    go_idle();

    // Pause for 10 clocks mid-frame 1 delays the next advance by exactly 10 clocks.
    start_run(2'b00, 2'd0);
    repeat (6) step();
    pause = 1'b1;
    repeat (10) step();
    check("pause_hold", 32'(frame), 1);
    pause = 1'b0;
    repeat (2) step();
    check("pause_resume_f1", 32'(frame), 1);
    step();
    check("pause_resume_f2", 32'(frame), 2);
    go_idle();

    // speed=1: two clocks per frame; then address check on frame 2.
    start_run(2'b00, 2'd1);
    repeat (3) step();
    check("spd1_f1", 32'(frame), 1);
    step();
    check("spd1_f1_hold", 32'(frame), 1);
    ram_addr_x = 8'd3; ram_addr_y = 8'd5;
    step();
    check("spd1_f2", 32'(frame), 2);
    step();
    check("addr_171", 32'(mem_addr), 171);
    check("addr_valid", 32'(addr_valid), 1);
    ram_addr_x = 8'd8;
    step();
    check("addr_oob_valid", 32'(addr_valid), 0);
    check("addr_oob_zero", 32'(mem_addr), 0);
    ram_addr_x = 8'd2;

    // stop and start together: stop wins.
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    check("ss_busy", 32'(busy), 0);
    check("ss_frame", 32'(frame), 0);

    // Reset on the cycle that would have wrapped: no done pulse.
    start_run(2'b00, 2'd0);
    repeat (16) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstrun_done", 32'(done), 0);
    check("rstrun_frame", 32'(frame), 0);
    check("rstrun_busy", 32'(busy), 0);
    check("rstrun_valid", 32'(addr_valid), 0);

    // Randomized phase, checked by the per-cycle compare.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 2));
      mode       = 2'($urandom_range(0, 3));
      ram_addr_x = 8'($urandom_range(0, 9));
      ram_addr_y = 8'($urandom_range(0, 9));
      step();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
